// File: rtl/my_6d5d.sv
// Receive-side 6b/5b decoder with running-disparity tracking, error flags, lock FSM
// and an optional saturating error counter (enabled by MY_6D5D_ERRCNT_EN).
module my_6d5d #(
  parameter int GOOD_TO_LOCK  = 4,
  parameter int BAD_TO_UNLOCK = 3,
  parameter int ERRCNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          mem,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [4:0]          bits,
  output logic                code_err,
  output logic                disp_err,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                CDR,
  output logic                locked,
  output logic [ERRCNT_W-1:0] err_cnt,
  input  logic                err_clr
);

  localparam int CNT_MAX = (GOOD_TO_LOCK > BAD_TO_UNLOCK) ? GOOD_TO_LOCK : BAD_TO_UNLOCK;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

  function automatic logic [2:0] weight(input logic [5:0] s);
    logic [2:0] w;
    w = '0;
    for (int i = 0; i < 6; i++) w = w + {2'b00, s[i]};
    return w;
  endfunction

  // Weight-2 table; weight-4 codewords are looked up through their complement.
  // Returns {hit, data}.
  function automatic logic [5:0] map_neg(input logic [5:0] s);
    case (s)
      6'b011000: return {1'b1, 5'b00000};
      6'b100010: return {1'b1, 5'b00001};
      6'b010010: return {1'b1, 5'b00010};
      6'b001010: return {1'b1, 5'b00100};
      6'b000110: return {1'b1, 5'b01000};
      6'b101000: return {1'b1, 5'b01111};
      6'b100100: return {1'b1, 5'b10000};
      6'b000101: return {1'b1, 5'b10111};
      6'b001100: return {1'b1, 5'b11000};
      6'b001001: return {1'b1, 5'b11011};
      6'b010001: return {1'b1, 5'b11101};
      6'b100001: return {1'b1, 5'b11110};
      6'b010100: return {1'b1, 5'b11111};
      default:   return {1'b0, 5'b00000};
    endcase
  endfunction

  function automatic logic [4:0] map_bal(input logic [5:0] s);
    case (s)
      6'b110001: return 5'b00011;
      6'b101001: return 5'b00101;
      6'b011001: return 5'b00110;
      6'b100101: return 5'b01001;
      6'b010101: return 5'b01010;
      6'b110100: return 5'b01011;
      6'b001101: return 5'b01100;
      6'b101100: return 5'b01101;
      6'b011100: return 5'b01110;
      6'b100011: return 5'b10001;
      6'b010011: return 5'b10010;
      6'b110010: return 5'b10011;
      6'b001011: return 5'b10100;
      6'b101010: return 5'b10101;
      6'b011010: return 5'b10110;
      6'b100110: return 5'b11001;
      6'b010110: return 5'b11010;
      6'b001110: return 5'b11100;
      6'b000111: return 5'b00111;
      6'b111000: return 5'b00111;
      default:   return 5'b00000;
    endcase
  endfunction

  logic             out_valid_q;
  logic [4:0]       bits_q;
  logic             code_err_q;
  logic             disp_err_q;
  logic             cdr_q;
  logic             accept;

  logic [2:0]       dec_w;
  logic [5:0]       dec_hit;
  logic [4:0]       dec_bits;
  logic             dec_code_err;
  logic             dec_disp_err;
  logic             cdr_next;
  logic             errored;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    dec_w        = weight(mem);
    dec_hit      = '0;
    dec_bits     = '0;
    dec_code_err = 1'b0;
    dec_disp_err = 1'b0;
    cdr_next     = cdr_q;
    case (dec_w)
      3'd2: begin
        dec_hit = map_neg(mem);
        if (dec_hit[5]) begin
          dec_bits     = dec_hit[4:0];
          dec_disp_err = !cdr_q;
          cdr_next     = 1'b0;
        end else begin
          dec_code_err = 1'b1;
        end
      end
      3'd4: begin
        dec_hit = map_neg(~mem);
        if (dec_hit[5]) begin
          dec_bits     = dec_hit[4:0];
          dec_disp_err = cdr_q;
          cdr_next     = 1'b1;
        end else begin
          dec_code_err = 1'b1;
        end
      end
      3'd3: begin
        dec_bits = map_bal(mem);
        // The two forms of 00111 are balanced but still carry a disparity rule.
        if (mem == 6'b000111)      dec_disp_err = !cdr_q;
        else if (mem == 6'b111000) dec_disp_err = cdr_q;
      end
      default: dec_code_err = 1'b1;
    endcase
  end

  assign errored = dec_code_err || dec_disp_err;

  // NOTE: sequential state is written with non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      bits_q      <= '0;
      code_err_q  <= 1'b0;
      disp_err_q  <= 1'b0;
      cdr_q       <= 1'b0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        bits_q      <= dec_bits;
        code_err_q  <= dec_code_err;
        disp_err_q  <= dec_disp_err;
        cdr_q       <= cdr_next;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign bits      = bits_q;
  assign code_err  = code_err_q;
  assign disp_err  = disp_err_q;
  assign CDR       = cdr_q;

  lock_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNLOCKED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      case (state_q)
        UNLOCKED: begin
          if (errored) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_W'(GOOD_TO_LOCK - 1)) begin
            state_d = LOCKED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        LOCKED: begin
          if (!errored) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_W'(BAD_TO_UNLOCK - 1)) begin
            state_d = UNLOCKED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = UNLOCKED;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign locked = (state_q == LOCKED);

`ifdef MY_6D5D_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (err_clr) begin
      err_cnt_q <= '0;
    end else if (accept && errored && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_my_6d5d.sv
// Directed scoreboard bench for my_6d5d; err_cnt expectations follow MY_6D5D_ERRCNT_EN.
module tb_my_6d5d;

`ifdef MY_6D5D_ERRCNT_EN
  localparam bit EC_EN = 1'b1;
`else
  localparam bit EC_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [5:0] mem;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] bits;
  logic       code_err;
  logic       disp_err;
  logic       out_valid;
  logic       out_ready;
  logic       cdr;
  logic       locked;
  logic [7:0] err_cnt;
  logic       err_clr;

  my_6d5d #(.GOOD_TO_LOCK(4), .BAD_TO_UNLOCK(3), .ERRCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .mem(mem), .in_valid(in_valid), .in_ready(in_ready),
    .bits(bits), .code_err(code_err), .disp_err(disp_err), .out_valid(out_valid),
    .out_ready(out_ready), .CDR(cdr), .locked(locked), .err_cnt(err_cnt), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] bits;
    logic       code_err;
    logic       disp_err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    n_cmp++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s/queue: observed empty scoreboard expected an entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "/out_valid"}, out_valid, 1);
      check({tag, "/bits"}, bits, e.bits);
      check({tag, "/code_err"}, code_err, e.code_err);
      check({tag, "/disp_err"}, disp_err, e.disp_err);
    end
  endtask

  task automatic send(input string tag, input logic [5:0] sym, input logic [4:0] eb,
                      input logic ec, input logic ed, input logic clr);
    @(negedge clk);
    mem       = sym;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    err_clr   = clr;
    exp_q.push_back('{bits: eb, code_err: ec, disp_err: ed});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    err_clr  = 1'b0;
    pop_check(tag);
  endtask

  task automatic check_err(input string tag, input int cnt);
    check(tag, err_cnt, EC_EN ? cnt : 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; mem = '0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst/in_ready", in_ready, 1);
    check("rst/out_valid", out_valid, 0);
    check("rst/bits", bits, 0);
    check("rst/code_err", code_err, 0);
    check("rst/disp_err", disp_err, 0);
    check("rst/cdr", cdr, 0);
    check("rst/locked", locked, 0);
    check("rst/err_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle/out_valid", out_valid, 0);
    check("idle/in_ready", in_ready, 1);
    check("idle/cdr", cdr, 0);

    // Balanced disparity alternation.
    send("pos_0", 6'b100111, 5'b00000, 1'b0, 1'b0, 1'b0);
    check("pos_0/cdr", cdr, 1);
    send("neg_0", 6'b011000, 5'b00000, 1'b0, 1'b0, 1'b0);
    check("neg_0/cdr", cdr, 0);

    // Disparity error with simultaneous clear: clear must win.
    send("disp", 6'b011000, 5'b00000, 1'b0, 1'b1, 1'b1);
    check("disp/cdr", cdr, 0);
    check_err("disp/err_clr_wins", 0);
    send("d7_neg", 6'b111000, 5'b00111, 1'b0, 1'b0, 1'b0);
    check("d7_neg/cdr", cdr, 0);

    // Code errors.
    send("cerr_w2", 6'b110000, 5'b00000, 1'b1, 1'b0, 1'b0);
    check("cerr_w2/cdr", cdr, 0);
    send("cerr_w6", 6'b111111, 5'b00000, 1'b1, 1'b0, 1'b0);
    check("cerr_w6/cdr", cdr, 0);
    check_err("cerr/err_cnt", 2);

    // Code error at CDR=1 must not disturb CDR; then the CDR=1 form of 00111.
    send("pos_1", 6'b100111, 5'b00000, 1'b0, 1'b0, 1'b0);
    send("cerr_w0", 6'b000000, 5'b00000, 1'b1, 1'b0, 1'b0);
    check("cerr_w0/cdr", cdr, 1);
    send("d7_pos", 6'b000111, 5'b00111, 1'b0, 1'b0, 1'b0);
    check("d7_pos/cdr", cdr, 1);
    check_err("cerr_w0/err_cnt", 3);

    // Backpressure.
    send("bp_first", 6'b110001, 5'b00011, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    mem = 6'b101001; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp/in_ready_low", in_ready, 0);
      check("bp/bits_hold", bits, 5'b00011);
      check("bp/out_valid_hold", out_valid, 1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp/in_ready_release", in_ready, 1);
    exp_q.push_back('{bits: 5'b00101, code_err: 1'b0, disp_err: 1'b0});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pop_check("bp_second");
    check("bp/locked", locked, 0);
    check("bp/cdr", cdr, 1);

    // Mid-stream reset with an output pending and CDR=1.
    @(negedge clk);
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("mrst/out_valid", out_valid, 0);
    check("mrst/cdr", cdr, 0);
    check("mrst/bits", bits, 0);
    check("mrst/err_cnt", err_cnt, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Lock acquisition.
    send("lk_0", 6'b110001, 5'b00011, 1'b0, 1'b0, 1'b0);
    send("lk_1", 6'b101001, 5'b00101, 1'b0, 1'b0, 1'b0);
    send("lk_2", 6'b011001, 5'b00110, 1'b0, 1'b0, 1'b0);
    check("lk_2/locked", locked, 0);
    send("lk_3", 6'b100101, 5'b01001, 1'b0, 1'b0, 1'b0);
    check("lk_3/locked", locked, 1);

    // Loss of lock: 2 bad, 1 good, 3 bad.
    send("ul_b0", 6'b000000, 5'b00000, 1'b1, 1'b0, 1'b0);
    send("ul_b1", 6'b011000, 5'b00000, 1'b0, 1'b1, 1'b0);
    check("ul_b1/locked", locked, 1);
    send("ul_g0", 6'b010101, 5'b01010, 1'b0, 1'b0, 1'b0);
    send("ul_b2", 6'b111111, 5'b00000, 1'b1, 1'b0, 1'b0);
    send("ul_b3", 6'b110000, 5'b00000, 1'b1, 1'b0, 1'b0);
    check("ul_b3/locked", locked, 1);
    send("ul_b4", 6'b001111, 5'b00000, 1'b1, 1'b0, 1'b0);
    check("ul_b4/locked", locked, 0);
    check_err("ul/err_cnt", 5);

    // Saturation of the error counter.
    exp_err = 5;
    for (int i = 0; i < 260; i++) begin
      send("sat", 6'b111111, 5'b00000, 1'b1, 1'b0, 1'b0);
      if (exp_err < 255) exp_err++;
    end
    check_err("sat/err_cnt", exp_err);
    send("sat_clr", 6'b010101, 5'b01010, 1'b0, 1'b0, 1'b1);
    check_err("sat_clr/err_cnt", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/my_6d5d.md
# my_6d5d

Receive-side 6b/5b decoder that pairs with the team's 5b/6b transmit encoder. It accepts one 6-bit line symbol per handshake and returns the 5-bit data value, tracking running disparity (CDR) exactly as the encoder does. It flags code violations and disparity violations, and maintains a lock indication for the link-status logic. It sits between the symbol deserializer and the byte/word assembler.

## Interface
- GOOD_TO_LOCK, 4: consecutive error-free accepted symbols required to assert `locked`.
- BAD_TO_UNLOCK, 3: consecutive errored accepted symbols required to deassert `locked`.
- ERRCNT_W, 8: width of the saturating error counter.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mem  input  6  received line symbol, bit 5 first-transmitted (same bit order the encoder drives).
- in_valid  input  1  `mem` is valid.
- in_ready  output  1  decoder can accept a symbol this cycle.
- bits  output  5  decoded data.
- code_err  output  1  symbol is not a legal codeword.
- disp_err  output  1  legal codeword with the wrong disparity for the current CDR.
- out_valid  output  1  `bits`, `code_err` and `disp_err` are valid.
- out_ready  input  1  downstream accepts the output.
- CDR  output  1  running disparity after the last accepted symbol; 1 means positive.
- locked  output  1  link lock status.
- err_cnt  output  ERRCNT_W  saturating count of errored symbols.
- err_clr  input  1  synchronous clear of `err_cnt`.

## Operation
- A symbol is accepted on a rising edge when `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. This gives a single output register with no bubble under continuous flow.
- Classification uses the weight w (number of ones in `mem`):
  - w=3: balanced. All 20 weight-3 patterns are legal.
  - w=2 codes mean negative disparity and are legal at CDR=1. Mapping code:data: 011000:00000, 100010:00001, 010010:00010, 001010:00100, 000110:01000, 101000:01111, 100100:10000, 000101:10111, 001100:11000, 001001:11011, 010001:11101, 100001:11110, 010100:11111.
  - w=4 codes are legal at CDR=0. Each w=4 codeword is the bitwise complement of the w=2 code for the same data.
  - Balanced mapping: 110001:00011, 101001:00101, 011001:00110, 100101:01001, 010101:01010, 110100:01011, 001101:01100, 101100:01101, 011100:01110, 100011:10001, 010011:10010, 110010:10011, 001011:10100, 101010:10101, 011010:10110, 100110:11001, 010110:11010, 001110:11100.
  - 000111 and 111000 both decode to 00111. 000111 is legal only at CDR=1 and 111000 only at CDR=0.
- Code error: w is 0, 1, 5 or 6, or `mem` is one of 110000, 000011, 001111, 111100. On a code error, bits=00000, disp_err=0 and CDR is unchanged.
- Disparity error applies to any legal codeword received at the wrong CDR:
  - a w=2 code at CDR=0;
  - a w=4 code at CDR=1;
  - the wrong-CDR form of 00111.
  - On a disparity error, `bits` still decodes normally.
- CDR update on every accepted non-code-error symbol: w=4 sets CDR=1, w=2 sets CDR=0, w=3 leaves it unchanged. This resynchronises CDR to the line after a disparity error.
- Lock FSM:
  - States UNLOCKED and LOCKED, each with a consecutive-symbol counter.
  - UNLOCKED: each clean symbol increments the good count and any error clears it. Reaching GOOD_TO_LOCK moves the FSM to LOCKED.
  - LOCKED: each errored symbol (code or disparity) increments the bad count and a clean symbol clears it. Reaching BAD_TO_UNLOCK moves the FSM to UNLOCKED.
  - Counters reset on every state change.
- `err_cnt` increments by 1 per accepted errored symbol and saturates at all-ones. If `err_clr` and an increment occur in the same cycle, clear wins.

## Timing
- Reset values: in_ready=1, out_valid=0, bits=0, code_err=0, disp_err=0, CDR=0, locked=0 (UNLOCKED, counters 0), err_cnt=0.
- Latency: one cycle. A symbol accepted at edge N appears on the outputs with out_valid=1 after edge N. CDR, locked and err_cnt also update at edge N.
- When out_valid=1 and out_ready=0, all outputs hold stable and no symbol is accepted.
- Asserting rst_n low mid-stream drops any pending output immediately and returns every register to its reset value.
- While `in_ready` is low, `mem` and `in_valid` are ignored.

## Configuration
- MY_6D5D_ERRCNT_EN
  - Defined: `err_cnt` and `err_clr` behave as specified above.
  - Undefined: the counter logic is compiled out, `err_cnt` is tied to 0 and `err_clr` is ignored. All other behaviour is unchanged.

## Test plan
- Reset, then idle: all outputs at their reset values, in_ready=1, CDR=0.
- CDR=0, send 100111 then 011000 -> bits=00000 both times, no errors, CDR goes 1 then 0.
- CDR=0, send 011000 -> bits=00000, disp_err=1, CDR=0. Then send 111000 -> bits=00111, no error, CDR=0.
- Send 110000, then 111111 -> code_err=1 and bits=00000 for both, CDR unchanged, err_cnt=2 (macro defined) or 0 (macro undefined).
- Backpressure: accept 110001, then hold out_ready=0 for 3 cycles while presenting 101001 -> in_ready=0, bits stays at 00011; on release, 101001 is accepted and bits=00101 on the next cycle.
- Lock: 4 clean symbols -> locked=1 after the 4th accept. Then 2 errored, 1 clean, 3 errored -> locked=0 only after the final 3rd consecutive error.
